unidade_controle_rodadas: RTL and testbench

Moore control unit that sequences the memory-game datapath (address counter, round counter, play register, memory comparator) for the round-based version of the game. Each round N requires the player to repeat memory entries 0..N; rounds progress until the last round is completed, a wrong play occurs, or the player times out. It sits between the top-level game circuit and its datapath. It drives the datapath's clear/count/load strobes and the acertou/errou/pronto indications.

---
 rtl/unidade_controle_rodadas.sv | 117 +++++++++++
 tb/tb_unidade_controle_rodadas.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/unidade_controle_rodadas.sv
// Moore control unit for the round-based memory game: sequences the datapath
// strobes, tracks the per-play timeout and reports the game outcome.
module unidade_controle_rodadas #(
    parameter int TIMEOUT_CICLOS = 3000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       tem_jogada,
    input  logic       igual,
    input  logic       fim_endereco,
    input  logic       fim_rodada,
    output logic       zeraE,
    output logic       contaE,
    output logic       zeraL,
    output logic       contaL,
    output logic       zeraR,
    output logic       registraR,
    output logic       acertou,
    output logic       errou,
    output logic       timeout,
    output logic       pronto,
    output logic [3:0] db_estado
);

    localparam int TW = $clog2(TIMEOUT_CICLOS);
    localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT_CICLOS - 1);
    localparam logic [TW-1:0] TIMER_UM  = TW'(1);

    typedef enum logic [3:0] {
        INICIAL        = 4'h0,
        PREPARACAO     = 4'h1,
        INICIA_RODADA  = 4'h2,
        ESPERA_JOGADA  = 4'h3,
        REGISTRA       = 4'h4,
        COMPARACAO     = 4'h5,
        PROXIMO        = 4'h6,
        PROXIMA_RODADA = 4'h7,
        FIM_ACERTOU    = 4'hA,
        FIM_ERROU      = 4'hE,
        FIM_TIMEOUT    = 4'hC
    } estado_t;

    estado_t       estado;
    estado_t       prox;
    logic [TW-1:0] timer;
    logic [9:0]    saidas;

    // Bit order: zeraE contaE zeraL contaL zeraR registraR acertou errou timeout pronto
    function automatic logic [9:0] decodifica(input estado_t e);
        logic [9:0] s;
        s = '0;
        case (e)
            PREPARACAO:     s = 10'b1010100000;
            INICIA_RODADA:  s = 10'b1000000000;
            REGISTRA:       s = 10'b0000010000;
            PROXIMO:        s = 10'b0100000000;
            PROXIMA_RODADA: s = 10'b0001000000;
            FIM_ACERTOU:    s = 10'b0000001001;
            FIM_ERROU:      s = 10'b0000000101;
            FIM_TIMEOUT:    s = 10'b0000000111;
            default:        s = '0;
        endcase
        return s;
    endfunction

    always_comb begin
        prox = INICIAL;
        case (estado)
            INICIAL:        prox = iniciar ? PREPARACAO : INICIAL;
            PREPARACAO:     prox = INICIA_RODADA;
            INICIA_RODADA:  prox = ESPERA_JOGADA;
            // A play landing on the last timer cycle still counts as a play.
            ESPERA_JOGADA: begin
                if (tem_jogada)              prox = REGISTRA;
                else if (timer == TIMER_MAX) prox = FIM_TIMEOUT;
                else                         prox = ESPERA_JOGADA;
            end
            REGISTRA:       prox = COMPARACAO;
            COMPARACAO: begin
                if (!igual)             prox = FIM_ERROU;
                else if (!fim_endereco) prox = PROXIMO;
                else if (!fim_rodada)   prox = PROXIMA_RODADA;
                else                    prox = FIM_ACERTOU;
            end
            PROXIMO:        prox = ESPERA_JOGADA;
            PROXIMA_RODADA: prox = INICIA_RODADA;
            FIM_ACERTOU:    prox = iniciar ? PREPARACAO : FIM_ACERTOU;
            FIM_ERROU:      prox = iniciar ? PREPARACAO : FIM_ERROU;
            FIM_TIMEOUT:    prox = iniciar ? PREPARACAO : FIM_TIMEOUT;
            default:        prox = INICIAL;
        endcase
    end

    // Outputs are registered from the next state, so they track the state
    // register exactly as a combinational Moore decode would.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado    <= INICIAL;
            timer     <= '0;
            saidas    <= '0;
            db_estado <= 4'h0;
        end else begin
            estado    <= prox;
            saidas    <= decodifica(prox);
            db_estado <= prox;
            if (estado == ESPERA_JOGADA && prox == ESPERA_JOGADA)
                timer <= (timer == TIMER_MAX) ? timer : timer + TIMER_UM;
            else
                timer <= '0;
        end
    end

    assign {zeraE, contaE, zeraL, contaL, zeraR, registraR,
            acertou, errou, timeout, pronto} = saidas;

endmodule

// File: tb/tb_unidade_controle_rodadas.sv
// Directed bench for unidade_controle_rodadas: a vector table for the opening
// rounds plus hand-written sequences for win, loss, timeout and async reset.
module tb_unidade_controle_rodadas;

    logic       clock;
    logic       reset;
    logic       iniciar, tem_jogada, igual, fim_endereco, fim_rodada;
    logic       zeraE, contaE, zeraL, contaL, zeraR, registraR;
    logic       acertou, errou, timeout, pronto;
    logic [3:0] db_estado;
    logic [9:0] outs;

    int total = 0;
    int bad   = 0;
    logic [13:0] exp_q[$];

    // Expected output words: zeraE contaE zeraL contaL zeraR registraR acertou errou timeout pronto
    localparam logic [9:0] O_NONE = 10'b0000000000;
    localparam logic [9:0] O_PREP = 10'b1010100000;
    localparam logic [9:0] O_INI  = 10'b1000000000;
    localparam logic [9:0] O_REG  = 10'b0000010000;
    localparam logic [9:0] O_CE   = 10'b0100000000;
    localparam logic [9:0] O_CL   = 10'b0001000000;
    localparam logic [9:0] O_WIN  = 10'b0000001001;
    localparam logic [9:0] O_ERR  = 10'b0000000101;
    localparam logic [9:0] O_TO   = 10'b0000000111;

    typedef struct {
        logic       ini, tj, ig, fe, fr;
        logic [3:0] st;
        logic [9:0] o;
    } vec_t;

    vec_t tabela[$];

    unidade_controle_rodadas #(.TIMEOUT_CICLOS(8)) dut (
        .clock(clock), .reset(reset), .iniciar(iniciar), .tem_jogada(tem_jogada),
        .igual(igual), .fim_endereco(fim_endereco), .fim_rodada(fim_rodada),
        .zeraE(zeraE), .contaE(contaE), .zeraL(zeraL), .contaL(contaL),
        .zeraR(zeraR), .registraR(registraR), .acertou(acertou), .errou(errou),
        .timeout(timeout), .pronto(pronto), .db_estado(db_estado)
    );

    assign outs = {zeraE, contaE, zeraL, contaL, zeraR, registraR,
                   acertou, errou, timeout, pronto};

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_now(input logic [3:0] st, input logic [9:0] o, input string name);
        logic [13:0] exp_v;
        exp_q.push_back({st, o});
        exp_v = exp_q.pop_front();
        total++;
        if ({db_estado, outs} !== exp_v) begin
            bad++;
            $display("FAIL %s: got estado=%h outs=%b, want estado=%h outs=%b",
                     name, db_estado, outs, exp_v[13:10], exp_v[9:0]);
        end
    endtask

    // Drive inputs mid-cycle, let one rising edge pass, then check.
    task automatic step(input logic ini, input logic tj, input logic ig, input logic fe,
                        input logic fr, input logic [3:0] st, input logic [9:0] o,
                        input string name);
        iniciar = ini; tem_jogada = tj; igual = ig; fim_endereco = fe; fim_rodada = fr;
        @(posedge clock);
        #1;
        check_now(st, o, name);
    endtask

    task automatic add(input logic ini, input logic tj, input logic ig, input logic fe,
                       input logic fr, input logic [3:0] st, input logic [9:0] o);
        vec_t v;
        v.ini = ini; v.tj = tj; v.ig = ig; v.fe = fe; v.fr = fr; v.st = st; v.o = o;
        tabela.push_back(v);
    endtask

    // One correct play from espera_jogada; path depends on fe/fr.
    task automatic play_ok(input logic fe, input logic fr);
        step(0, 1, 1, fe, fr, 4'h4, O_REG, "play_registra");
        step(0, 0, 1, fe, fr, 4'h5, O_NONE, "play_comparacao");
        if (!fe) begin
            step(0, 0, 1, fe, fr, 4'h6, O_CE, "play_proximo");
            step(0, 0, 1, fe, fr, 4'h3, O_NONE, "play_espera");
        end else if (!fr) begin
            step(0, 0, 1, fe, fr, 4'h7, O_CL, "play_proxima_rodada");
            step(0, 0, 1, fe, fr, 4'h2, O_INI, "play_inicia_rodada");
            step(0, 0, 1, fe, fr, 4'h3, O_NONE, "play_espera");
        end else begin
            step(0, 0, 1, fe, fr, 4'hA, O_WIN, "play_fim_acertou");
        end
    endtask

    initial begin
        reset = 1'b0; iniciar = 0; tem_jogada = 0; igual = 0; fim_endereco = 0; fim_rodada = 0;

        // Opening: start, round 0 (one play), round 1 (two plays)
        add(1, 0, 0, 0, 0, 4'h1, O_PREP);
        add(0, 0, 0, 0, 0, 4'h2, O_INI);
        add(0, 0, 0, 0, 0, 4'h3, O_NONE);
        add(0, 1, 1, 1, 0, 4'h4, O_REG);
        add(0, 0, 1, 1, 0, 4'h5, O_NONE);
        add(0, 0, 1, 1, 0, 4'h7, O_CL);
        add(0, 0, 1, 1, 0, 4'h2, O_INI);
        add(0, 0, 1, 1, 0, 4'h3, O_NONE);
        add(0, 1, 1, 0, 0, 4'h4, O_REG);
        add(0, 1, 1, 0, 0, 4'h5, O_NONE);  // tem_jogada held into registra is lost
        add(0, 0, 1, 0, 0, 4'h6, O_CE);
        add(0, 0, 1, 0, 0, 4'h3, O_NONE);
        add(1, 1, 1, 1, 0, 4'h4, O_REG);   // iniciar ignored mid-game
        add(1, 0, 1, 1, 0, 4'h5, O_NONE);
        add(0, 0, 1, 1, 0, 4'h7, O_CL);
        add(0, 0, 1, 1, 0, 4'h2, O_INI);
        add(0, 0, 1, 1, 0, 4'h3, O_NONE);

        #12;
        check_now(4'h0, O_NONE, "reset_held");
        #5;
        reset = 1'b1;
        #1;
        check_now(4'h0, O_NONE, "after_release");
        step(0, 0, 0, 0, 0, 4'h0, O_NONE, "idle_inicial");

        for (int i = 0; i < tabela.size(); i++)
            step(tabela[i].ini, tabela[i].tj, tabela[i].ig, tabela[i].fe, tabela[i].fr,
                 tabela[i].st, tabela[i].o, $sformatf("vec%0d", i));

        // Rounds 2 and 3 to a win
        play_ok(0, 0); play_ok(0, 0); play_ok(1, 0);
        play_ok(0, 0); play_ok(0, 0); play_ok(0, 0); play_ok(1, 1);
        for (int i = 0; i < 3; i++)
            step(0, 1, 0, 0, 0, 4'hA, O_WIN, "win_hold");
        step(1, 0, 0, 0, 0, 4'h1, O_PREP, "win_restart");

        // Second game: wrong third play of round 2
        step(0, 0, 0, 0, 0, 4'h2, O_INI, "g2_inicia");
        step(0, 0, 0, 0, 0, 4'h3, O_NONE, "g2_espera");
        play_ok(1, 0);
        play_ok(0, 0); play_ok(1, 0);
        play_ok(0, 0); play_ok(0, 0);
        step(0, 1, 0, 1, 0, 4'h4, O_REG, "wrong_registra");
        step(0, 0, 0, 1, 0, 4'h5, O_NONE, "wrong_comparacao");
        step(0, 0, 0, 1, 0, 4'hE, O_ERR, "wrong_fim_errou");
        step(0, 0, 0, 1, 0, 4'hE, O_ERR, "wrong_hold");
        step(1, 0, 0, 0, 0, 4'h1, O_PREP, "err_restart");
        step(1, 0, 0, 0, 0, 4'h2, O_INI, "g3_inicia");
        step(1, 0, 0, 0, 0, 4'h3, O_NONE, "g3_espera");

        // Timeout: 8 cycles in espera_jogada without a play
        for (int i = 0; i < 7; i++)
            step(0, 0, 0, 0, 0, 4'h3, O_NONE, $sformatf("to_wait%0d", i));
        step(0, 0, 0, 0, 0, 4'hC, O_TO, "to_fim_timeout");
        step(0, 0, 0, 0, 0, 4'hC, O_TO, "to_hold");
        step(1, 0, 0, 0, 0, 4'h1, O_PREP, "to_restart");
        step(0, 0, 0, 0, 0, 4'h2, O_INI, "g4_inicia");
        step(0, 0, 0, 0, 0, 4'h3, O_NONE, "g4_espera");

        // Play on the 8th cycle wins over the timeout
        for (int i = 0; i < 7; i++)
            step(0, 0, 0, 0, 0, 4'h3, O_NONE, $sformatf("edge_wait%0d", i));
        step(0, 1, 1, 0, 0, 4'h4, O_REG, "edge_play_wins");
        step(0, 0, 1, 0, 0, 4'h5, O_NONE, "edge_comparacao");
        step(0, 0, 1, 0, 0, 4'h6, O_CE, "edge_proximo");
        step(0, 0, 1, 0, 0, 4'h3, O_NONE, "edge_espera");

        // Timer restarts per play: another full 7-cycle wait is safe
        for (int i = 0; i < 7; i++)
            step(0, 0, 0, 0, 0, 4'h3, O_NONE, $sformatf("rearm_wait%0d", i));
        step(0, 1, 1, 0, 0, 4'h4, O_REG, "rearm_play");
        step(0, 0, 1, 0, 0, 4'h5, O_NONE, "rearm_comparacao");
        step(0, 0, 1, 0, 0, 4'h6, O_CE, "rearm_proximo");

        // Asynchronous reset while in proximo
        #2;
        reset = 1'b0;
        #1;
        check_now(4'h0, O_NONE, "async_reset");
        @(posedge clock);
        #1;
        check_now(4'h0, O_NONE, "reset_across_edge");
        #3;
        reset = 1'b1;
        step(0, 0, 1, 0, 0, 4'h0, O_NONE, "post_reset_idle0");
        step(0, 0, 1, 0, 0, 4'h0, O_NONE, "post_reset_idle1");
        step(1, 0, 0, 0, 0, 4'h1, O_PREP, "post_reset_start");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
